// File: rtl/wsc_pkg.sv
// Shared constants and state type for the 20x20 sliding-window scan controller.
package wsc_pkg;
    localparam int unsigned WIN    = 20;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned X_W    = 9;
    localparam int unsigned Y_W    = 8;
    localparam int unsigned COL_W  = 5;
    localparam int unsigned ENG_AW = 9;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ROW_WAIT,
        EMIT,
        ADVANCE
    } state_t;
endpackage

// File: rtl/wsc_if.sv
// Pixel-memory, integral-engine and window-handshake bundle of the scan controller.
interface wsc_if;
    import wsc_pkg::*;

    logic              pix_rd;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;
    logic              eng_we;
    logic [ENG_AW-1:0] eng_addr;
    logic [DATA_W-1:0] eng_data;
    logic              eng_done;
    logic              win_valid;
    logic [X_W-1:0]    win_x;
    logic [Y_W-1:0]    win_y;
    logic              win_ready;
    logic              busy;
    logic              frame_done;

    modport master (
        output pix_rd, pix_addr, eng_we, eng_addr, eng_data,
               win_valid, win_x, win_y, busy, frame_done,
        input  pix_data, eng_done, win_ready
    );

    modport slave (
        input  pix_rd, pix_addr, eng_we, eng_addr, eng_data,
               win_valid, win_x, win_y, busy, frame_done,
        output pix_data, eng_done, win_ready
    );
endinterface

// File: rtl/wsc_addr_gen.sv
// Window position, row and column counters plus a multiplier-free pixel address accumulator.
module wsc_addr_gen
    import wsc_pkg::*;
#(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240,
    parameter int unsigned STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              rd_step,
    input  logic              row_step,
    input  logic              win_step,
    output logic [X_W-1:0]    wx,
    output logic [Y_W-1:0]    wy,
    output logic [COL_W-1:0]  col,
    output logic              row_last,
    output logic              frame_last,
    output logic [ADDR_W-1:0] pix_addr
);
    logic [COL_W-1:0]  r;
    logic [ADDR_W-1:0] win_base;
    logic [ADDR_W-1:0] row_base;
    logic              wrap;
    logic [Y_W:0]      wy_step;
    logic [X_W-1:0]    wx_next;
    logic [Y_W-1:0]    wy_next;
    logic [ADDR_W-1:0] win_base_next;

    // Next window: step right, or wrap to column 0 one stride further down.
    assign wrap          = (10'(wx) + 10'(STEP + WIN)) > 10'(IMG_W);
    assign wy_step       = 9'(wy) + 9'(STEP);
    assign frame_last    = wrap && ((wy_step + 9'(WIN)) > 9'(IMG_H));
    assign wx_next       = wrap ? '0 : wx + X_W'(STEP);
    assign wy_next       = wrap ? wy + Y_W'(STEP) : wy;
    assign win_base_next = wrap ? win_base - ADDR_W'(wx) + ADDR_W'(STEP * IMG_W)
                                : win_base + ADDR_W'(STEP);
    assign row_last      = (r == COL_W'(WIN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wx       <= '0;
            wy       <= '0;
            r        <= '0;
            col      <= '0;
            win_base <= '0;
            row_base <= '0;
            pix_addr <= '0;
        end else if (load) begin
            wx       <= '0;
            wy       <= '0;
            r        <= '0;
            col      <= '0;
            win_base <= '0;
            row_base <= '0;
            pix_addr <= '0;
        end else if (win_step) begin
            wx       <= wx_next;
            wy       <= wy_next;
            r        <= '0;
            col      <= '0;
            win_base <= win_base_next;
            row_base <= win_base_next;
            pix_addr <= win_base_next;
        end else if (row_step) begin
            r        <= r + COL_W'(1);
            col      <= '0;
            row_base <= row_base + ADDR_W'(IMG_W);
            pix_addr <= row_base + ADDR_W'(IMG_W);
        end else if (rd_step) begin
            col      <= col + COL_W'(1);
            pix_addr <= pix_addr + ADDR_W'(1);
        end
    end
endmodule

// File: rtl/window_scan_ctrl.sv
// Frame scan controller: streams 20x20 windows row by row into the integral engine.
// Build option WSC_ABORT_EN adds an abort input that returns to IDLE from any state.
module window_scan_ctrl
    import wsc_pkg::*;
#(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240,
    parameter int unsigned STEP  = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic START,
`ifdef WSC_ABORT_EN
    input  logic abort,
`endif
    wsc_if.master bus
);
    state_t            state;
    logic              pix_rd_q;
    logic              eng_we_q;
    logic [ENG_AW-1:0] eng_addr_q;
    logic              win_valid_q;
    logic              busy_q;
    logic              frame_done_q;

    logic              abort_c;
    logic              load_c;
    logic              rd_step_c;
    logic              row_step_c;
    logic              win_step_c;
    logic              col_last_c;

    logic [X_W-1:0]    wx;
    logic [Y_W-1:0]    wy;
    logic [COL_W-1:0]  col;
    logic              row_last;
    logic              frame_last;
    logic [ADDR_W-1:0] pix_addr;

`ifdef WSC_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    assign col_last_c = (col == COL_W'(WIN - 1));
    assign load_c     = !abort_c && (state == IDLE) && START;
    assign rd_step_c  = !abort_c && (state == FETCH) && pix_rd_q && !col_last_c;
    assign row_step_c = !abort_c && (state == ROW_WAIT) && bus.eng_done;
    assign win_step_c = !abort_c && (state == ADVANCE);

    wsc_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .STEP  (STEP)
    ) u_addr_gen (
        .clk        (CLK),
        .rst        (RESET),
        .load       (load_c),
        .rd_step    (rd_step_c),
        .row_step   (row_step_c),
        .win_step   (win_step_c),
        .wx         (wx),
        .wy         (wy),
        .col        (col),
        .row_last   (row_last),
        .frame_last (frame_last),
        .pix_addr   (pix_addr)
    );

    // Scan sequencer; every read is echoed as an engine write one cycle later.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            pix_rd_q     <= 1'b0;
            eng_we_q     <= 1'b0;
            eng_addr_q   <= '0;
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            eng_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            if (abort_c) begin
                state       <= IDLE;
                pix_rd_q    <= 1'b0;
                win_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START) begin
                            state    <= FETCH;
                            pix_rd_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    FETCH: begin
                        eng_we_q   <= pix_rd_q;
                        eng_addr_q <= ENG_AW'(col);
                        if (pix_rd_q) begin
                            pix_rd_q <= !col_last_c;
                        end else begin
                            state <= ROW_WAIT;
                        end
                    end
                    ROW_WAIT: begin
                        if (bus.eng_done) begin
                            if (row_last) begin
                                state       <= EMIT;
                                win_valid_q <= 1'b1;
                            end else begin
                                state    <= FETCH;
                                pix_rd_q <= 1'b1;
                            end
                        end
                    end
                    EMIT: begin
                        if (bus.win_ready) begin
                            state       <= ADVANCE;
                            win_valid_q <= 1'b0;
                        end
                    end
                    ADVANCE: begin
                        if (frame_last) begin
                            state        <= IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            pix_rd_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pix_rd     = pix_rd_q;
    assign bus.pix_addr   = pix_addr;
    assign bus.eng_we     = eng_we_q;
    assign bus.eng_addr   = eng_addr_q;
    // Memory data is passed straight through so it lands in the cycle it is returned.
    assign bus.eng_data   = eng_we_q ? bus.pix_data : '0;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_x      = wx;
    assign bus.win_y      = wy;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule
